// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: decode-to-execute pipeline register with stall, flush and bubble insertion.
// Control bits are cleared together with out_valid so a bubble can never cause a side effect.
module id_ex_pipe_reg #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  in_valid,
  input  logic [3:0]            exec_command_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  wb_enable_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic                  imm_in,
  input  logic [WIDTH-1:0]      pc_in,
  input  logic [WIDTH-1:0]      val_rn_in,
  input  logic [WIDTH-1:0]      val_rm_in,
  input  logic [11:0]           shift_operand_in,
  input  logic [23:0]           signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  input  logic                  carry_in,
  output logic                  out_valid,
  output logic [3:0]            exec_command,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_enable,
  output logic                  b,
  output logic                  s,
  output logic                  imm,
  output logic [WIDTH-1:0]      pc,
  output logic [WIDTH-1:0]      val_rn,
  output logic [WIDTH-1:0]      val_rm,
  output logic [11:0]           shift_operand,
  output logic [23:0]           signed_imm_24,
  output logic [REG_ADDR_W-1:0] dest,
  output logic [REG_ADDR_W-1:0] src1,
  output logic [REG_ADDR_W-1:0] src2,
  output logic                  carry
);
  localparam int CW = 11;
  localparam int DW = 3 * WIDTH + 36 + 3 * REG_ADDR_W + 1;
  logic [CW-1:0] ctl;
  logic [DW-1:0] dat;
  logic [CW+DW-1:0] q;
  always_comb begin
    ctl = in_valid ? {1'b1, exec_command_in, mem_read_in, mem_write_in, wb_enable_in, b_in, s_in, imm_in} : '0;
    dat = {pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in, dest_in, src1_in, src2_in, carry_in};
  end
  // flush outranks freeze so a stalled instruction behind a taken branch is still killed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (flush) q <= '0;
    else if (!freeze) q <= {ctl, dat};
  assign {out_valid, exec_command, mem_read, mem_write, wb_enable, b, s, imm,
          pc, val_rn, val_rm, shift_operand, signed_imm_24, dest, src1, src2, carry} = q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: table-driven vectors with a scoreboard queue, plus reset sequences.
module tb_id_ex_pipe_reg;
  logic clk = 0, rst_n = 0, flush, freeze, in_valid;
  logic [3:0] exec_command_in;
  logic mem_read_in, mem_write_in, wb_enable_in, b_in, s_in, imm_in, carry_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0] dest_in, src1_in, src2_in;
  logic out_valid, mem_read, mem_write, wb_enable, b, s, imm, carry;
  logic [3:0] exec_command, dest, src1, src2;
  logic [31:0] pc, val_rn, val_rm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [155:0] obs;
  int checks = 0, errors = 0;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze), .in_valid(in_valid),
    .exec_command_in(exec_command_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .wb_enable_in(wb_enable_in), .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .pc_in(pc_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .shift_operand_in(shift_operand_in),
    .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
    .carry_in(carry_in), .out_valid(out_valid), .exec_command(exec_command), .mem_read(mem_read),
    .mem_write(mem_write), .wb_enable(wb_enable), .b(b), .s(s), .imm(imm), .pc(pc),
    .val_rn(val_rn), .val_rm(val_rm), .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
    .dest(dest), .src1(src1), .src2(src2), .carry(carry)
  );

  always #5 clk = ~clk;
  assign obs = {out_valid, exec_command, mem_read, mem_write, wb_enable, b, s, imm, pc, val_rn, val_rm,
                shift_operand, signed_imm_24, dest, src1, src2, carry};

  typedef struct {
    logic fl, fz, v;
    logic [3:0] ec;
    logic [5:0] ctl;
    logic [31:0] rn;
    logic [3:0] dst;
    logic c;
    logic e_v;
    logic [3:0] e_ec;
    logic [5:0] e_ctl;
    logic [31:0] e_rn;
    logic [3:0] e_dst;
    logic e_c;
    int mode;
  } vec_t;
  typedef struct {
    string nm;
    logic [155:0] e, m;
  } exp_t;
  localparam logic [155:0] ALL = '1;
  localparam logic [155:0] CTL_ONLY = {11'h7FF, 145'd0};
  vec_t tbl[13];
  exp_t sb[$];
  exp_t it;

  function automatic logic [155:0] model(logic v, logic [3:0] ec, logic [5:0] ctl, logic [31:0] rn,
                                         logic [3:0] dst, logic c);
    return {v, ec, ctl, rn + 32'd4, rn, ~rn, rn[11:0], rn[23:0] ^ 24'hABCDEF,
            dst, 4'(dst + 4'd1), 4'(dst + 4'd2), c};
  endfunction

  task automatic drive(logic fl, logic fz, logic v, logic [3:0] ec, logic [5:0] ctl, logic [31:0] rn,
                       logic [3:0] dst, logic c);
    flush = fl; freeze = fz; in_valid = v; exec_command_in = ec;
    {mem_read_in, mem_write_in, wb_enable_in, b_in, s_in, imm_in} = ctl;
    pc_in = rn + 32'd4; val_rn_in = rn; val_rm_in = ~rn; shift_operand_in = rn[11:0];
    signed_imm_24_in = rn[23:0] ^ 24'hABCDEF; dest_in = dst; src1_in = dst + 4'd1; src2_in = dst + 4'd2;
    carry_in = c;
  endtask

  task automatic cmp(string nm, logic [155:0] e, logic [155:0] m);
    checks++;
    if (((obs ^ e) & m) != '0) begin
      errors++;
      $display("FAIL %s: got %h expected %h (mask %h)", nm, obs, e, m);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // fields: fl fz v ec ctl(mr,mw,wb,b,s,i) rn dst c | e_v e_ec e_ctl e_rn e_dst e_c mode(0=ctl only,1=full,2=zero)
    tbl[0]  = '{0,0,1,4'h2,6'b001000,32'h5,4'd3,1'b1,        1,4'h2,6'b001000,32'h5,4'd3,1'b1,1};
    tbl[1]  = '{0,0,1,4'h4,6'b101000,32'hA,4'd7,1'b0,        1,4'h4,6'b101000,32'hA,4'd7,1'b0,1};
    tbl[2]  = '{0,1,1,4'h9,6'b010000,32'hB,4'd9,1'b1,        1,4'h4,6'b101000,32'hA,4'd7,1'b0,1};
    tbl[3]  = '{0,1,1,4'h9,6'b010000,32'hB,4'd9,1'b1,        1,4'h4,6'b101000,32'hA,4'd7,1'b0,1};
    tbl[4]  = '{0,1,1,4'h9,6'b010000,32'hB,4'd9,1'b1,        1,4'h4,6'b101000,32'hA,4'd7,1'b0,1};
    tbl[5]  = '{0,0,1,4'h9,6'b010000,32'hB,4'd9,1'b1,        1,4'h9,6'b010000,32'hB,4'd9,1'b1,1};
    tbl[6]  = '{1,1,1,4'h3,6'b111111,32'hC,4'd5,1'b1,        0,4'h0,6'b000000,32'h0,4'd0,1'b0,2};
    tbl[7]  = '{1,0,1,4'h3,6'b111111,32'hC,4'd5,1'b1,        0,4'h0,6'b000000,32'h0,4'd0,1'b0,2};
    tbl[8]  = '{0,0,0,4'h5,6'b100110,32'hD,4'd2,1'b1,        0,4'h0,6'b000000,32'h0,4'd0,1'b0,0};
    tbl[9]  = '{0,1,1,4'h6,6'b111111,32'hE,4'd4,1'b0,        0,4'h0,6'b000000,32'h0,4'd0,1'b0,0};
    tbl[10] = '{0,0,1,4'hF,6'b111111,32'hFFFFFFFF,4'hF,1'b1, 1,4'hF,6'b111111,32'hFFFFFFFF,4'hF,1'b1,1};
    tbl[11] = '{0,1,0,4'h1,6'b000001,32'h1,4'd1,1'b0,        1,4'hF,6'b111111,32'hFFFFFFFF,4'hF,1'b1,1};
    tbl[12] = '{0,0,0,4'h1,6'b000001,32'h1,4'd1,1'b0,        0,4'h0,6'b000000,32'h0,4'd0,1'b0,0};

    drive(0, 0, 1, 4'hF, 6'h3F, 32'hDEADBEEF, 4'hE, 1);
    repeat (2) @(posedge clk);
    #1 cmp("reset_held", '0, ALL);
    #4 rst_n = 1;
    @(posedge clk); #1 cmp("first_capture", model(1, 4'hF, 6'h3F, 32'hDEADBEEF, 4'hE, 1), ALL);
    #2 rst_n = 0;
    #1 cmp("async_reset_pulse", '0, ALL);
    #1 rst_n = 1;
    #1 cmp("after_pulse_no_edge", '0, ALL);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].fl, tbl[i].fz, tbl[i].v, tbl[i].ec, tbl[i].ctl, tbl[i].rn, tbl[i].dst, tbl[i].c);
      sb.push_back('{$sformatf("vec%0d", i),
                     tbl[i].mode == 2 ? '0 : model(tbl[i].e_v, tbl[i].e_ec, tbl[i].e_ctl, tbl[i].e_rn, tbl[i].e_dst, tbl[i].e_c),
                     tbl[i].mode == 0 ? CTL_ONLY : ALL});
      @(posedge clk); #1;
      it = sb.pop_front();
      cmp(it.nm, it.e, it.m);
    end

    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 4'(k), 6'b001000, 32'h100 * k + 32'h7, 4'(k), k[0]);
      sb.push_back('{$sformatf("stream%0d", k), model(1, 4'(k), 6'b001000, 32'h100 * k + 32'h7, 4'(k), k[0]), ALL});
      @(posedge clk); #1;
      it = sb.pop_front();
      cmp(it.nm, it.e, it.m);
    end
    #3 rst_n = 0;
    #1 cmp("midstream_reset", '0, ALL);
    repeat (2) @(posedge clk);
    #1 cmp("reset_held_2cyc", '0, ALL);
    drive(0, 0, 1, 4'h6, 6'b100001, 32'h12345678, 4'd10, 1);
    #4 rst_n = 1;
    #1 cmp("release_no_edge", '0, ALL);
    @(posedge clk); #1 cmp("release_first_edge", model(1, 4'h6, 6'b100001, 32'h12345678, 4'd10, 1), ALL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
